// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state type and tree-PLRU helpers for icache_nway
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REFILL_REQ,
    REFILL_DATA,
    REFILL_DONE,
    INVAL
  } state_t;

  localparam int MAX_WAYS = 8;
  localparam int PLRU_MAX = MAX_WAYS - 1;

  typedef logic [PLRU_MAX-1:0] plru_t;

  function automatic int words_per_line(input int offset_len);
    return 1 << (offset_len - 2);
  endfunction

  function automatic int plru_width(input int way_cnt);
    return (way_cnt > 1) ? way_cnt - 1 : 1;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 / 2n+2, bit=1 steers to the upper child.
  function automatic logic [2:0] plru_victim(input plru_t bits, input int levels);
    logic [2:0] way_al;
    logic [2:0] node;
    way_al = '0;
    node   = '0;
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        way_al[2-l] = bits[node];
        node        = {node[1:0], 1'b0} + 3'd1 + {2'b0, bits[node]};
      end
    end
    return way_al >> (3 - levels);
  endfunction

  function automatic plru_t plru_touch(input plru_t bits, input logic [2:0] way, input int levels);
    plru_t      r;
    logic [2:0] node;
    logic [2:0] way_al;
    logic       dir;
    r      = bits;
    node   = '0;
    way_al = way << (3 - levels);
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        dir     = way_al[2-l];
        r[node] = ~dir;
        node    = {node[1:0], 1'b0} + 3'd1 + {2'b0, dir};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_nway_if.sv
// rtl/icache_nway_if.sv - fetch, invalidate and refill-bridge signals of icache_nway
interface icache_nway_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_miss;
  logic [31:0] cpu_rdata;
  logic        inv_req;
  logic        inv_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, inv_req, mem_gnt, mem_rvalid, mem_rdata,
    input  cpu_miss, cpu_rdata, inv_busy, mem_req, mem_addr
  );

  modport slave (
    input  cpu_req, cpu_addr, inv_req, mem_gnt, mem_rvalid, mem_rdata,
    output cpu_miss, cpu_rdata, inv_busy, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one cache way: flop valid bits, tag array and line data array
module icache_way
  import icache_pkg::*;
#(
  parameter int OFFSET_LEN = 5,
  parameter int INDEX_LEN  = 7,
  parameter int TAG_LEN    = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_LEN-1:0]  rd_set,
  input  logic [OFFSET_LEN-3:0] rd_word,
  output logic                  rd_valid,
  output logic [TAG_LEN-1:0]    rd_tag,
  output logic [31:0]           rd_data,
  input  logic [INDEX_LEN-1:0]  wr_set,
  input  logic                  word_we,
  input  logic [OFFSET_LEN-3:0] word_sel,
  input  logic [31:0]           word_data,
  input  logic                  tag_we,
  input  logic [TAG_LEN-1:0]    tag_data,
  input  logic                  set_clr
);
  localparam int SETS = 1 << INDEX_LEN;
  localparam int W    = words_per_line(OFFSET_LEN);

  logic [SETS-1:0]    valid;
  logic [TAG_LEN-1:0] tags [SETS];
  logic [31:0]        data [SETS][W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (set_clr) begin
      valid[wr_set] <= 1'b0;
    end else if (tag_we) begin
      valid[wr_set] <= 1'b1;
    end
  end

  // Arrays carry no reset; valid alone decides whether a line exists.
  always_ff @(posedge clk) begin
    if (tag_we) tags[wr_set] <= tag_data;
    if (word_we) data[wr_set][word_sel] <= word_data;
  end

  assign rd_valid = valid[rd_set];
  assign rd_tag   = tags[rd_set];
  assign rd_data  = data[rd_set][rd_word];

endmodule

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative I-cache with tree PLRU, word-serial refill
// and invalidate-all sweep; hits answer combinationally in the request cycle.
module icache_nway
  import icache_pkg::*;
#(
  parameter int OFFSET_LEN = 5,
  parameter int INDEX_LEN  = 7,
  parameter int TAG_LEN    = 20,
  parameter int WAY_CNT    = 2
) (
  input logic          clk,
  input logic          rst_n,
  icache_nway_if.slave bus
);
  localparam int W      = words_per_line(OFFSET_LEN);
  localparam int WB     = OFFSET_LEN - 2;
  localparam int SETS   = 1 << INDEX_LEN;
  localparam int LEVELS = $clog2(WAY_CNT);
  localparam int PLRU_W = plru_width(WAY_CNT);

  state_t state, state_nx;

  logic [WB-1:0]          beat;
  logic [INDEX_LEN-1:0]   sweep;
  logic                   inv_pend;
  logic [31-OFFSET_LEN:0] line;
  logic [2:0]             victim;
  logic [PLRU_W-1:0]      plru [SETS];

  logic [TAG_LEN-1:0]   req_tag;
  logic [INDEX_LEN-1:0] req_set;
  logic [WB-1:0]        req_word;
  logic                 unused_addr_bits;
  logic [INDEX_LEN-1:0] line_set;
  logic [TAG_LEN-1:0]   line_tag;
  logic [INDEX_LEN-1:0] wr_set;
  logic                 fill_we;

  logic [WAY_CNT-1:0] way_valid;
  logic [TAG_LEN-1:0] way_tag  [WAY_CNT];
  logic [31:0]        way_data [WAY_CNT];

  logic        hit;
  logic [2:0]  hit_way;
  logic [31:0] hit_data;
  logic [2:0]  victim_sel;

  assign req_tag          = bus.cpu_addr[31:32-TAG_LEN];
  assign req_set          = bus.cpu_addr[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN];
  assign req_word         = bus.cpu_addr[OFFSET_LEN-1:2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];
  assign line_set         = line[INDEX_LEN-1:0];
  assign line_tag         = line[31-OFFSET_LEN -: TAG_LEN];
  assign wr_set           = (state == INVAL) ? sweep : line_set;
  assign fill_we          = (state == REFILL_DATA) && bus.mem_rvalid;

  for (genvar g = 0; g < WAY_CNT; g++) begin : g_way
    icache_way #(
      .OFFSET_LEN(OFFSET_LEN),
      .INDEX_LEN (INDEX_LEN),
      .TAG_LEN   (TAG_LEN)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_set   (req_set),
      .rd_word  (req_word),
      .rd_valid (way_valid[g]),
      .rd_tag   (way_tag[g]),
      .rd_data  (way_data[g]),
      .wr_set   (wr_set),
      .word_we  (fill_we && (victim == 3'(g))),
      .word_sel (beat),
      .word_data(bus.mem_rdata),
      .tag_we   ((state == REFILL_DONE) && (victim == 3'(g))),
      .tag_data (line_tag),
      .set_clr  (state == INVAL)
    );
  end

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        hit      = 1'b1;
        hit_way  = 3'(w);
        hit_data = way_data[w];
      end
    end
  end

  always_comb begin
    victim_sel = plru_victim(plru_t'(plru[req_set]), LEVELS);
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_sel = 3'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.inv_req || inv_pend)    state_nx = INVAL;
        else if (bus.cpu_req && !hit)   state_nx = REFILL_REQ;
      end
      REFILL_REQ:  if (bus.mem_gnt) state_nx = REFILL_DATA;
      REFILL_DATA: if (bus.mem_rvalid && (beat == WB'(W - 1))) state_nx = REFILL_DONE;
      REFILL_DONE: state_nx = IDLE;
      INVAL:       if (sweep == '1) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  assign bus.cpu_miss  = bus.cpu_req && !(hit && (state == IDLE));
  assign bus.cpu_rdata = hit_data;
  assign bus.inv_busy  = inv_pend || (state == INVAL);
  assign bus.mem_req   = (state == REFILL_REQ);
  assign bus.mem_addr  = (state == REFILL_REQ) ? {line, {OFFSET_LEN{1'b0}}} : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      sweep    <= '0;
      inv_pend <= 1'b0;
      line     <= '0;
      victim   <= '0;
    end else begin
      // IDLE either starts the sweep or has nothing pending, so it always clears.
      if (state == IDLE)    inv_pend <= 1'b0;
      else if (bus.inv_req) inv_pend <= 1'b1;
      if ((state == IDLE) && (state_nx == REFILL_REQ)) begin
        line   <= bus.cpu_addr[31:OFFSET_LEN];
        victim <= victim_sel;
      end
      if (fill_we)          beat  <= beat + 1'b1;
      if (state == INVAL)   sweep <= sweep + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else if ((state == INVAL) && (state_nx == IDLE)) begin
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else if (state == REFILL_DONE) begin
      plru[line_set] <= PLRU_W'(plru_touch(plru_t'(plru[line_set]), victim, LEVELS));
    end else if ((state == IDLE) && bus.cpu_req && hit) begin
      plru[req_set] <= PLRU_W'(plru_touch(plru_t'(plru[req_set]), hit_way, LEVELS));
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - randomized bench for icache_nway (4 ways, 8-word lines, 128 sets)
// against a behavioural cache model with named-bit tree PLRU.
module tb_icache_nway;
  localparam int OFF  = 5;
  localparam int IDX  = 7;
  localparam int TAGL = 20;
  localparam int WAYS = 4;
  localparam int W    = 8;
  localparam int SETS = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_nway_if bus();

  icache_nway #(
    .OFFSET_LEN(OFF),
    .INDEX_LEN (IDX),
    .TAG_LEN   (TAGL),
    .WAY_CNT   (WAYS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  bit          m_valid [WAYS][SETS];
  int          m_tag   [WAYS][SETS];
  logic [31:0] m_data  [WAYS][SETS][W];
  bit          m_root  [SETS];
  bit          m_lo    [SETS];
  bit          m_hi    [SETS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
      m_root[s] = 1'b0;
      m_lo[s]   = 1'b0;
      m_hi[s]   = 1'b0;
    end
  endfunction

  function automatic int m_lookup(input int s, input int tg);
    for (int w = 0; w < WAYS; w++) if (m_valid[w][s] && m_tag[w][s] == tg) return w;
    return -1;
  endfunction

  // root: 0 -> evict from ways 0/1, 1 -> ways 2/3; lo/hi pick within the pair
  function automatic int m_victim(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[w][s]) return w;
    if (!m_root[s]) return m_lo[s] ? 1 : 0;
    return m_hi[s] ? 3 : 2;
  endfunction

  function automatic void m_touch(input int s, input int w);
    m_root[s] = (w < 2);
    if (w < 2) m_lo[s] = (w == 0);
    else       m_hi[s] = (w == 2);
  endfunction

  task automatic access(input logic [31:0] addr, input int gnt_dly, input bit gap,
                        input logic [31:0] base, input int inv_beat, input int rst_beat);
    int s, tg, wd, way, stalls;
    logic [31:0] line, v;
    s    = int'((addr >> OFF) & (SETS - 1));
    tg   = int'(addr >> (OFF + IDX));
    wd   = int'((addr >> 2) & (W - 1));
    line = addr & ~32'(W * 4 - 1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    @(negedge clk);
    way = m_lookup(s, tg);
    if (way >= 0) begin
      check("hit_miss", bus.cpu_miss, 1'b0);
      check("hit_data", bus.cpu_rdata, m_data[way][s][wd]);
      m_touch(s, way);
      step();
      return;
    end
    check("miss_flag", bus.cpu_miss, 1'b1);
    check("idle_no_req", {bus.mem_req, bus.mem_addr[30:0]}, 32'd0);
    stalls = 1;
    way = m_victim(s);
    step();
    for (int d = 0; d <= gnt_dly; d++) begin
      bus.mem_gnt    = (d == gnt_dly);
      bus.mem_rvalid = (d < gnt_dly);
      bus.mem_rdata  = 32'hDEAD_0000 | 32'(d);
      @(negedge clk);
      check("req_held", bus.mem_req, 1'b1);
      check("req_addr", bus.mem_addr, line);
      stalls += int'(bus.cpu_miss);
      step();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    for (int b = 0; b < W; b++) begin
      if (b == rst_beat) begin
        bus.mem_rvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_inv_busy", bus.inv_busy, 1'b0);
        check("rst_miss", bus.cpu_miss, 1'b1);
        m_clear();
        return;
      end
      if (gap && b > 0) begin
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        stalls += int'(bus.cpu_miss);
        step();
      end
      v = (base != 0) ? base + 32'(b) : $urandom;
      m_data[way][s][b] = v;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v;
      bus.inv_req    = (b == inv_beat);
      @(negedge clk);
      stalls += int'(bus.cpu_miss);
      step();
      bus.inv_req = 1'b0;
      if (b == inv_beat) check("inv_busy_pend", bus.inv_busy, 1'b1);
    end
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("done_no_req", bus.mem_req, 1'b0);
    stalls += int'(bus.cpu_miss);
    step();
    @(negedge clk);
    m_valid[way][s] = 1'b1;
    m_tag[way][s]   = tg;
    m_touch(s, way);
    check("fill_hit", bus.cpu_miss, 1'b0);
    check("fill_data", bus.cpu_rdata, m_data[way][s][wd]);
    check("stall_cycles", stalls, 32'(3 + gnt_dly + W + (gap ? W - 1 : 0)));
    step();
  endtask

  initial begin
    int n;
    int pool [3];
    int s, t, wd;
    pool = '{0, 1, 127};
    rst_n          = 1'b1;
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = 32'h0;
    bus.inv_req    = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    m_clear();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_miss", bus.cpu_miss, 1'b1);
    check("reset_mem_req", bus.mem_req, 1'b0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_inv_busy", bus.inv_busy, 1'b0);
    check("reset_rdata", bus.cpu_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    bus.cpu_req = 1'b0;

    access(32'h1FC0_0000, 0, 1'b0, 32'hA0, -1, -1);
    access(32'h1FC0_001C, 0, 1'b0, 32'h0, -1, -1);
    check("cold_word7", bus.cpu_rdata, 32'hA7);

    access(32'h0000_7020, 0, 1'b0, 32'h0, -1, 3);
    step();
    rst_n          = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    check("stray_idle_miss", bus.cpu_miss, 1'b0);
    step();
    bus.mem_rvalid = 1'b0;
    access(32'h0000_7020, 0, 1'b0, 32'h0, -1, -1);
    access(32'h1FC0_0000, 0, 1'b0, 32'h0, -1, -1);

    access(32'h0000_0000, 0, 1'b0, 32'h0, -1, -1);
    access(32'h0000_1000, 0, 1'b0, 32'h0, -1, -1);
    access(32'h0000_2000, 0, 1'b0, 32'h0, -1, -1);
    access(32'h0000_3000, 0, 1'b0, 32'h0, -1, -1);
    access(32'h0000_0004, 0, 1'b0, 32'h0, -1, -1);
    access(32'h0000_4000, 0, 1'b0, 32'h0, -1, -1);
    access(32'h0000_0008, 0, 1'b0, 32'h0, -1, -1);

    access(32'h0000_5024, 5, 1'b1, 32'h0, -1, -1);

    access(32'h0000_6000, 1, 1'b0, 32'h0, 2, -1);
    bus.cpu_addr = 32'h0000_6000;
    bus.cpu_req  = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.inv_busy) break;
      check("sweep_miss", bus.cpu_miss, 1'b1);
      n++;
      step();
    end
    bus.cpu_req = 1'b0;
    check("sweep_cycles", n, 32'd128);
    m_clear();
    step();
    access(32'h0000_6000, 0, 1'b0, 32'h0, -1, -1);
    access(32'h0000_7020, 0, 1'b0, 32'h0, -1, -1);

    for (int i = 0; i < 60; i++) begin
      t  = $urandom_range(0, 5);
      s  = pool[$urandom_range(0, 2)];
      wd = $urandom_range(0, W - 1);
      access((32'(t * 32'h111) << 12) | (32'(s) << 5) | (32'(wd) << 2),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 32'h0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised N-way set-associative instruction cache between the IF stage and the AXI read bridge. It replaces the fixed 2-way, whole-line-refill ICache with:
- configurable way count, using tree pseudo-LRU replacement;
- word-serial refill with a beat counter;
- flop-held valid bits cleared by reset;
- an invalidate-all sweep for the CACHE instruction.

Hits return data combinationally in the request cycle.

## Interface
- OFFSET_LEN, 5, log2 line bytes; words per line W = 2^(OFFSET_LEN-2)
- INDEX_LEN, 7, log2 sets
- TAG_LEN, 20, must equal 32-INDEX_LEN-OFFSET_LEN
- WAY_CNT, 2, power of two, 1..8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cpu_req  in  1  fetch request
- cpu_addr  in  32  fetch address; bits [1:0] ignored
- cpu_miss  out  1  stall: cpu_req & !(hit & state==IDLE)
- cpu_rdata  out  32  hit word; 0 when no hit
- inv_req  in  1  invalidate-all request, one-cycle pulse
- inv_busy  out  1  high while a sweep is pending or running
- mem_req  out  1  refill request, held until mem_gnt
- mem_addr  out  32  line-aligned refill address; 0 when mem_req low
- mem_gnt  in  1  bridge accepted the request
- mem_rvalid  in  1  one refill beat valid
- mem_rdata  in  32  beat data, word order 0..W-1

## Operation
- Address split: tag=[31:32-TAG_LEN], index=[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN], word=[OFFSET_LEN-1:2].
- Hit: any way with valid & tag match; data from that way (lowest way if several). In IDLE a hit updates PLRU to point away from the hit way.
- States: IDLE, REFILL_REQ, REFILL_DATA, REFILL_DONE, INVAL.
- IDLE -> INVAL when inv_req or an invalidate is pending (priority over misses).
- IDLE -> REFILL_REQ on cpu_req & !hit. Latch the line address and victim way.
  - Victim is the lowest-numbered invalid way; else the PLRU victim. With WAY_CNT=1 the victim is always way 0.
- REFILL_REQ: mem_req=1 and mem_addr = latched line; go to REFILL_DATA on mem_gnt.
- REFILL_DATA: each mem_rvalid writes mem_rdata into victim word[beat] and increments beat. After beat W-1, go to REFILL_DONE.
- REFILL_DONE: write tag and set valid for the victim; PLRU points away from the victim; go to IDLE.
- INVAL: clear valid of all ways at set = sweep counter, one set per cycle. After set 2^INDEX_LEN-1, clear PLRU and return to IDLE. inv_busy drops the same edge.
- The refill always completes to the latched line, even if cpu_addr or cpu_req changes. IDLE re-evaluates the current address.
- inv_req during a refill is recorded as pending and taken on the first IDLE cycle. inv_busy is high from the pulse onward.
- mem_rvalid outside REFILL_DATA is ignored.

## Timing
- Reset (rst_n low, any state): state IDLE, all valid=0, PLRU=0, beat=0, sweep=0, pending inv=0. Outputs: mem_req=0, mem_addr=0, inv_busy=0, cpu_rdata=0, cpu_miss=cpu_req.
- Reset mid-refill abandons the line; no tag is written.
- Hit latency 0: cpu_rdata is valid in the cycle cpu_req is presented.
- Miss at cycle 0, gnt at cycle 1, back-to-back beats at cycles 2..W+1, DONE at W+2, hit at W+3. With W=8, cpu_miss is high for 11 cycles.
- mem_req holds and mem_addr is stable until the edge sampling mem_gnt=1.
- Invalidate sweep takes exactly 2^INDEX_LEN cycles in INVAL. cpu_miss stays high for any request during the sweep.

## Structure
- Package icache_pkg: state enum, localparam computation for W and the PLRU width (WAY_CNT-1 bits per set), and the PLRU victim/update functions.
- Sub-module icache_way, instantiated WAY_CNT times:
  - contents: tag+valid array and W-word data array;
  - reads: asynchronous, indexed by set;
  - writes: per-word write enable, tag write, set-clear input for invalidation.
- PLRU and the FSM live in the top module.

## Test plan
- Cold miss, W=8, WAY_CNT=2: req 0x1FC0_0000, gnt immediate, beats 0xA0..0xA7 -> mem_addr 0x1FC0_0000; later req 0x1FC0_001C hits with rdata 0xA7; 11 stall cycles.
- Conflict, WAY_CNT=4: fill lines 0x0000_0000, 0x0000_1000, 0x0000_2000, 0x0000_3000 (same set), touch line 0x0000_0000, miss on 0x0000_4000 -> victim is not way 0; 0x0000_0000 still hits.
- Back-pressure: gnt delayed 5 cycles, rvalid gapped every other cycle -> mem_req and mem_addr stable, data correct, completion only after 8 beats.
- Invalidate: inv_req pulse mid-refill -> refill finishes, then 128-cycle sweep with inv_busy high; prior hit lines now miss.
- Reset at beat 3 of a refill -> mem_req=0 next cycle; stray rvalid ignored; same address misses again.
- WAY_CNT=1: two lines in one set alternate -> each access misses and replaces way 0.
